// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding, RAM read
// latency and the default drain length.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Image/kernel RAM read latency in cycles; datapath strobes trail addresses by this much.
  localparam int DATA_LAT = 1;

  // Cycles from the last read issue to done: datapath pipeline plus max pool.
  localparam int DEF_DRAIN_CYC = 12;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// RAM read and datapath control bundle of the convolution sequencer.
// master: sequencer side, slave: RAM/datapath side.
interface conv_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int SHFT_WIDTH = 4
);

  logic                  img_rd_en;
  logic [ADDR_WIDTH-1:0] img_addr;
  logic                  kern_rd_en;
  logic [ADDR_WIDTH-1:0] kern_addr;
  logic                  dp_start;
  logic [2:0]            dp_mask;
  logic [SHFT_WIDTH-1:0] dp_shift;
  logic                  dp_clr_k_col_cnt;
  logic                  dp_clr_col_cnt;
  logic                  dp_accum_ovrflow;

  modport master (
    output img_rd_en, img_addr, kern_rd_en, kern_addr,
    output dp_start, dp_mask, dp_shift, dp_clr_k_col_cnt, dp_clr_col_cnt,
    input  dp_accum_ovrflow
  );

  modport slave (
    input  img_rd_en, img_addr, kern_rd_en, kern_addr,
    input  dp_start, dp_mask, dp_shift, dp_clr_k_col_cnt, dp_clr_col_cnt,
    output dp_accum_ovrflow
  );

endinterface

// File: rtl/conv_addr_gen.sv
// Address generator: four nested window counters (kc, kr, oc, orow) and
// running address bases, so no multiplier sits on the address path.
// Addresses are registered and describe the read being issued this cycle.
module conv_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  stride2_in,
  input  logic [DIM_WIDTH-1:0]  cols_in,
  input  logic [DIM_WIDTH-1:0]  rows_in,
  input  logic [DIM_WIDTH-1:0]  kern_in,
  input  logic [ADDR_WIDTH-1:0] img_base_in,
  input  logic [ADDR_WIDTH-1:0] kern_base_in,
  output logic [ADDR_WIDTH-1:0] img_addr,
  output logic [ADDR_WIDTH-1:0] kern_addr,
  output logic                  last,
  output logic                  win_first,
  output logic                  row_first
);

  localparam logic [DIM_WIDTH-1:0] ONE_D = DIM_WIDTH'(1);

  logic [DIM_WIDTH-1:0]  cols, rows, kdim;
  logic [DIM_WIDTH-1:0]  kc, kr, oc, orow;
  logic                  stride2;
  logic [ADDR_WIDTH-1:0] kern_base, line_base, win_base, row_base;

  logic [DIM_WIDTH:0]    oc_room, orow_room, step_sz;
  logic [DIM_WIDTH-1:0]  pos_step;
  logic [ADDR_WIDTH-1:0] col_step, row_step;
  logic                  kc_last, kr_last, oc_last, orow_last;

  // Loop-end detection and stride-dependent step sizes.
  // NOTE: every signal gets a value on every path, so no latch is inferred.
  always_comb begin
    step_sz   = stride2 ? (DIM_WIDTH+1)'(2) : (DIM_WIDTH+1)'(1);
    pos_step  = stride2 ? DIM_WIDTH'(2) : DIM_WIDTH'(1);
    col_step  = stride2 ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
    row_step  = stride2 ? ADDR_WIDTH'({cols, 1'b0}) : ADDR_WIDTH'(cols);
    // Remaining room to the last legal position; a stride that overshoots ends the loop.
    oc_room   = {1'b0, cols} - {1'b0, kdim} - {1'b0, oc};
    orow_room = {1'b0, rows} - {1'b0, kdim} - {1'b0, orow};
    kc_last   = (kc == kdim - ONE_D);
    kr_last   = (kr == kdim - ONE_D);
    oc_last   = (oc_room < step_sz);
    orow_last = (orow_room < step_sz);
    last      = kc_last & kr_last & oc_last & orow_last;
    win_first = (kc == '0) && (kr == '0);
    row_first = win_first && (oc == '0);
  end

  // Counter and running-base update: load on job start, advance one tap per step.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols      <= '0;
      rows      <= '0;
      kdim      <= '0;
      stride2   <= 1'b0;
      kc        <= '0;
      kr        <= '0;
      oc        <= '0;
      orow      <= '0;
      kern_base <= '0;
      line_base <= '0;
      win_base  <= '0;
      row_base  <= '0;
      img_addr  <= '0;
      kern_addr <= '0;
    end else if (load) begin
      cols      <= cols_in;
      rows      <= rows_in;
      kdim      <= kern_in;
      stride2   <= stride2_in;
      kc        <= '0;
      kr        <= '0;
      oc        <= '0;
      orow      <= '0;
      kern_base <= kern_base_in;
      line_base <= img_base_in;
      win_base  <= img_base_in;
      row_base  <= img_base_in;
      img_addr  <= img_base_in;
      kern_addr <= kern_base_in;
    end else if (step) begin
      if (!kc_last) begin
        kc        <= kc + ONE_D;
        img_addr  <= img_addr + ADDR_WIDTH'(1);
        kern_addr <= kern_addr + ADDR_WIDTH'(1);
      end else begin
        kc <= '0;
        if (!kr_last) begin
          // Next kernel row: kernel taps are contiguous, image jumps one line.
          kr        <= kr + ONE_D;
          line_base <= line_base + ADDR_WIDTH'(cols);
          img_addr  <= line_base + ADDR_WIDTH'(cols);
          kern_addr <= kern_addr + ADDR_WIDTH'(1);
        end else begin
          kr        <= '0;
          kern_addr <= kern_base;
          if (!oc_last) begin
            oc        <= oc + pos_step;
            win_base  <= win_base + col_step;
            line_base <= win_base + col_step;
            img_addr  <= win_base + col_step;
          end else begin
            oc <= '0;
            if (!orow_last) begin
              orow      <= orow + pos_step;
              row_base  <= row_base + row_step;
              win_base  <= row_base + row_step;
              line_base <= row_base + row_step;
              img_addr  <= row_base + row_step;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer top: job FSM, config latching and datapath strobe
// alignment. Optional stride-2 walk enabled by defining CONV_SEQ_STRIDE2_EN.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8,
  parameter int SHFT_WIDTH = 4,
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
`ifdef CONV_SEQ_STRIDE2_EN
  input  logic                  cfg_stride2,
`endif
  input  logic [DIM_WIDTH-1:0]  cfg_img_cols,
  input  logic [DIM_WIDTH-1:0]  cfg_img_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_kern_dim,
  input  logic [ADDR_WIDTH-1:0] cfg_img_base,
  input  logic [ADDR_WIDTH-1:0] cfg_kern_base,
  input  logic [2:0]            cfg_chan_mask,
  input  logic [SHFT_WIDTH-1:0] cfg_shift,
  conv_seq_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  ovf_sticky
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  state_t                 state;
  logic                   rd_en;
  logic [2:0]             mask_q;
  logic [SHFT_WIDTH-1:0]  shift_q;
  logic [CNT_W-1:0]       drain_cnt;
  logic [DATA_LAT-1:0][2:0] align_pipe;

  logic                   cfg_legal, gen_load, gen_step, gen_last;
  logic                   win_first, row_first, stride2_in;
  logic [ADDR_WIDTH-1:0]  img_addr, kern_addr;

`ifdef CONV_SEQ_STRIDE2_EN
  assign stride2_in = cfg_stride2;
`else
  assign stride2_in = 1'b0;
`endif

  assign cfg_legal = (cfg_kern_dim != '0) && (cfg_kern_dim <= cfg_img_cols) &&
                     (cfg_kern_dim <= cfg_img_rows);
  assign gen_load  = (state == ST_IDLE) && cmd_start && cfg_legal;
  assign gen_step  = (state == ST_RUN);

  conv_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .load         (gen_load),
    .step         (gen_step),
    .stride2_in   (stride2_in),
    .cols_in      (cfg_img_cols),
    .rows_in      (cfg_img_rows),
    .kern_in      (cfg_kern_dim),
    .img_base_in  (cfg_img_base),
    .kern_base_in (cfg_kern_base),
    .img_addr     (img_addr),
    .kern_addr    (kern_addr),
    .last         (gen_last),
    .win_first    (win_first),
    .row_first    (row_first)
  );

  // Job FSM with registered status outputs and latched job configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      ovf_sticky <= 1'b0;
      mask_q     <= '0;
      shift_q    <= '0;
      drain_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (busy && bus.dp_accum_ovrflow) ovf_sticky <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            if (cfg_legal) begin
              state      <= ST_RUN;
              rd_en      <= 1'b1;
              busy       <= 1'b1;
              ovf_sticky <= 1'b0;
              mask_q     <= cfg_chan_mask;
              shift_q    <= cfg_shift;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (gen_last) begin
            state     <= ST_DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= ST_DONE;
          else drain_cnt <= drain_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay start/clear strobes by the RAM latency so they meet the read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_pipe <= '0;
    end else begin
      align_pipe[0] <= {rd_en, rd_en & win_first, rd_en & row_first};
      for (int i = 1; i < DATA_LAT; i++) align_pipe[i] <= align_pipe[i-1];
    end
  end

  assign bus.img_rd_en        = rd_en;
  assign bus.kern_rd_en       = rd_en;
  assign bus.img_addr         = img_addr;
  assign bus.kern_addr        = kern_addr;
  assign bus.dp_start         = align_pipe[DATA_LAT-1][2];
  assign bus.dp_clr_k_col_cnt = align_pipe[DATA_LAT-1][1];
  assign bus.dp_clr_col_cnt   = align_pipe[DATA_LAT-1][0];
  assign bus.dp_mask          = mask_q;
  assign bus.dp_shift         = shift_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: address walk, strobe alignment, drain
// timing, illegal configs, overflow sticky, ignored restart, mid-job reset.
module tb_conv_seq_ctrl;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int SW    = 4;
  localparam int DRAIN = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_start = 1'b0;
  logic [DW-1:0] cfg_img_cols = '0, cfg_img_rows = '0, cfg_kern_dim = '0;
  logic [AW-1:0] cfg_img_base = '0, cfg_kern_base = '0;
  logic [2:0]    cfg_chan_mask = '0;
  logic [SW-1:0] cfg_shift = '0;
`ifdef CONV_SEQ_STRIDE2_EN
  logic          cfg_stride2 = 1'b0;
`endif
  logic          busy, done, cfg_err, ovf_sticky;

  conv_seq_ctrl_if #(.ADDR_WIDTH(AW), .SHFT_WIDTH(SW)) bus ();

  conv_seq_ctrl #(
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DW),
    .SHFT_WIDTH (SW),
    .DRAIN_CYC  (DRAIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_start     (cmd_start),
`ifdef CONV_SEQ_STRIDE2_EN
    .cfg_stride2   (cfg_stride2),
`endif
    .cfg_img_cols  (cfg_img_cols),
    .cfg_img_rows  (cfg_img_rows),
    .cfg_kern_dim  (cfg_kern_dim),
    .cfg_img_base  (cfg_img_base),
    .cfg_kern_base (cfg_kern_base),
    .cfg_chan_mask (cfg_chan_mask),
    .cfg_shift     (cfg_shift),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: logs issued addresses, strobe positions (in data cycles) and done.
  int            cyc = 0;
  int            rd_cnt = 0, start_cnt = 0, done_cnt = 0;
  int            en_skew = 0, stray = 0, first_rd_cyc = 0, done_cyc = 0;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] img_log[$], kern_log[$];
  int            clrk_log[$], clrc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.img_rd_en !== bus.kern_rd_en) en_skew++;
    if ((bus.dp_clr_k_col_cnt || bus.dp_clr_col_cnt) && !bus.dp_start) stray++;
    if (bus.img_rd_en === 1'b1) begin
      if (!prev_rd) first_rd_cyc = cyc;
      img_log.push_back(bus.img_addr);
      kern_log.push_back(bus.kern_addr);
      rd_cnt++;
    end
    prev_rd = (bus.img_rd_en === 1'b1);
    if (bus.dp_start === 1'b1) begin
      if (bus.dp_clr_k_col_cnt) clrk_log.push_back(start_cnt);
      if (bus.dp_clr_col_cnt) clrc_log.push_back(start_cnt);
      start_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_job(input int cols, input int rows, input int k,
                           input logic [AW-1:0] ib, input logic [AW-1:0] kb,
                           input logic [2:0] mask, input logic [SW-1:0] shift);
    @(negedge clk);
    cfg_img_cols  = DW'(cols);
    cfg_img_rows  = DW'(rows);
    cfg_kern_dim  = DW'(k);
    cfg_img_base  = ib;
    cfg_kern_base = kb;
    cfg_chan_mask = mask;
    cfg_shift     = shift;
    cmd_start     = 1'b1;
    @(negedge clk);
    cmd_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    @(negedge clk);
  endtask

  // Reference walk straight from the address formulas.
  task automatic check_addrs(input string tag, input int i0, input int cols, input int rows,
                             input int k, input int s, input logic [AW-1:0] ib,
                             input logic [AW-1:0] kb);
    int idx = 0;
    logic [AW-1:0] ea, ka;
    for (int orow = 0; orow <= rows - k; orow += s)
      for (int oc = 0; oc <= cols - k; oc += s)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            ea = ib + AW'((orow + kr) * cols + oc + kc);
            ka = kb + AW'(kr * k + kc);
            if (i0 + idx < img_log.size()) begin
              check($sformatf("%s_img%0d", tag, idx), img_log[i0+idx], ea);
              check($sformatf("%s_kern%0d", tag, idx), kern_log[i0+idx], ka);
            end
            idx++;
          end
    check({tag, "_reads"}, img_log.size() - i0, idx);
  endtask

  task automatic illegal_try(input string tag, input int cols, input int rows, input int k);
    int r0 = rd_cnt;
    @(negedge clk);
    cfg_img_cols = DW'(cols);
    cfg_img_rows = DW'(rows);
    cfg_kern_dim = DW'(k);
    cmd_start    = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    check({tag, "_err_pulse"}, cfg_err, 1);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_err_drop"}, cfg_err, 0);
    repeat (4) @(negedge clk);
    check({tag, "_no_reads"}, rd_cnt - r0, 0);
  endtask

  int i0, s0, k0, c0, d0, r0, n;
  int win1[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  initial begin
    bus.dp_accum_ovrflow = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_rd_en", bus.img_rd_en, 0);
    check("rst_img_addr", bus.img_addr, 0);
    check("rst_dp_start", bus.dp_start, 0);
    check("rst_dp_mask", bus.dp_mask, 0);
    check("rst_dp_shift", bus.dp_shift, 0);
    reset = 1'b1;
    @(negedge clk);

    // 4x4 image, K=3: 36 reads, 4 windows, 2 output rows.
    i0 = img_log.size(); s0 = start_cnt; k0 = clrk_log.size(); c0 = clrc_log.size(); d0 = done_cnt;
    start_job(4, 4, 3, 16'd0, 16'd0, 3'b111, 4'd5);
    check("t1_busy", busy, 1);
    wait_done("t1");
    check_addrs("t1", i0, 4, 4, 3, 1, 16'd0, 16'd0);
    for (int j = 0; j < 9; j++)
      if (i0 + j < img_log.size()) check($sformatf("t1_win1_%0d", j), img_log[i0+j], win1[j]);
    if (i0 + 9 < img_log.size()) check("t1_win2_start", img_log[i0+9], 1);
    check("t1_starts", start_cnt - s0, 36);
    check("t1_clrk_n", clrk_log.size() - k0, 4);
    for (int j = 0; j < 4; j++)
      if (k0 + j < clrk_log.size()) check($sformatf("t1_clrk%0d", j), clrk_log[k0+j] - s0, 9 * j);
    check("t1_clrc_n", clrc_log.size() - c0, 2);
    if (c0 + 1 < clrc_log.size()) begin
      check("t1_clrc0", clrc_log[c0] - s0, 0);
      check("t1_clrc1", clrc_log[c0+1] - s0, 18);
    end
    check("t1_done_lat", done_cyc - first_rd_cyc, 36 + 1 + DRAIN);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_busy_after", busy, 0);
    check("t1_mask", bus.dp_mask, 3'b111);
    check("t1_shift", bus.dp_shift, 5);
    check("t1_ovf", ovf_sticky, 0);

    // Illegal configurations.
    illegal_try("ill_k_gt_cols", 4, 4, 5);
    illegal_try("ill_k_zero", 4, 4, 0);
    illegal_try("ill_k_gt_rows", 8, 2, 3);

    // Overflow while idle must not set the sticky flag.
    bus.dp_accum_ovrflow = 1'b1;
    @(negedge clk);
    bus.dp_accum_ovrflow = 1'b0;
    @(negedge clk);
    check("ovf_idle", ovf_sticky, 0);

    // Overflow mid-run sets sticky through done; next start clears it.
    start_job(4, 4, 3, 16'd0, 16'd0, 3'b011, 4'd2);
    repeat (8) @(negedge clk);
    bus.dp_accum_ovrflow = 1'b1;
    @(negedge clk);
    bus.dp_accum_ovrflow = 1'b0;
    @(negedge clk);
    check("ovf_set", ovf_sticky, 1);
    wait_done("ovf");
    check("ovf_hold", ovf_sticky, 1);
    start_job(4, 4, 3, 16'd0, 16'd0, 3'b011, 4'd2);
    check("ovf_clear", ovf_sticky, 0);
    wait_done("ovf2");
    check("ovf_clear_end", ovf_sticky, 0);

    // Restart pulse during RUN is ignored.
    i0 = img_log.size(); d0 = done_cnt;
    start_job(4, 4, 3, 16'd16, 16'd32, 3'b110, 4'd9);
    repeat (5) @(negedge clk);
    cfg_kern_dim = 8'd2;
    cfg_shift    = 4'd1;
    cmd_start    = 1'b1;
    @(negedge clk);
    cmd_start    = 1'b0;
    wait_done("rst2");
    check_addrs("restart", i0, 4, 4, 3, 1, 16'd16, 16'd32);
    check("restart_done_once", done_cnt - d0, 1);
    check("restart_shift", bus.dp_shift, 9);

    // Asynchronous reset around read 10 aborts the job without done.
    r0 = rd_cnt; d0 = done_cnt; n = 0;
    start_job(4, 4, 3, 16'd0, 16'd0, 3'b111, 4'd3);
    while (rd_cnt - r0 < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached10", rd_cnt - r0 >= 10, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_img_rd", bus.img_rd_en, 0);
    check("abort_kern_rd", bus.kern_rd_en, 0);
    check("abort_img_addr", bus.img_addr, 0);
    check("abort_kern_addr", bus.kern_addr, 0);
    check("abort_dp_start", bus.dp_start, 0);
    check("abort_dp_mask", bus.dp_mask, 0);
    check("abort_dp_shift", bus.dp_shift, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle", busy, 0);

    // Normal job after reset: 5 cols x 4 rows, K=2, non-zero bases.
    i0 = img_log.size();
    start_job(5, 4, 2, 16'd100, 16'd200, 3'b101, 4'd7);
    wait_done("post");
    check_addrs("post", i0, 5, 4, 2, 1, 16'd100, 16'd200);
    check("post_mask", bus.dp_mask, 3'b101);

    // Single window with address wrap.
    i0 = img_log.size(); k0 = clrk_log.size(); c0 = clrc_log.size();
    start_job(3, 3, 3, 16'hFFFC, 16'hFFFE, 3'b001, 4'd0);
    wait_done("wrap");
    check_addrs("wrap", i0, 3, 3, 3, 1, 16'hFFFC, 16'hFFFE);
    check("wrap_clrk_n", clrk_log.size() - k0, 1);
    check("wrap_clrc_n", clrc_log.size() - c0, 1);

    // K=1: every data cycle opens a window.
    i0 = img_log.size(); k0 = clrk_log.size(); c0 = clrc_log.size();
    start_job(3, 2, 1, 16'd50, 16'd7, 3'b111, 4'd1);
    wait_done("k1");
    check_addrs("k1", i0, 3, 2, 1, 1, 16'd50, 16'd7);
    check("k1_clrk_n", clrk_log.size() - k0, 6);
    check("k1_clrc_n", clrc_log.size() - c0, 2);

`ifdef CONV_SEQ_STRIDE2_EN
    // Stride 2 on a 5x5 image, K=3: windows at 0, 2, 10, 12.
    i0 = img_log.size();
    cfg_stride2 = 1'b1;
    start_job(5, 5, 3, 16'd0, 16'd0, 3'b111, 4'd0);
    cfg_stride2 = 1'b0;
    wait_done("s2");
    check_addrs("s2", i0, 5, 5, 3, 2, 16'd0, 16'd0);
    if (i0 + 27 < img_log.size()) begin
      check("s2_w0", img_log[i0], 0);
      check("s2_w1", img_log[i0+9], 2);
      check("s2_w2", img_log[i0+18], 10);
      check("s2_w3", img_log[i0+27], 12);
    end
`endif

    check("rd_en_pair", en_skew, 0);
    check("stray_strobes", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
